uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sync2.sv | 26 ++
 rtl/uart_rx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud defaults, bit-timing helpers and the receiver state encoding.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ  = 50_000_000;
    localparam int DEFAULT_BAUD_RATE = 9600;
    localparam int BAUD_CNT_W        = 13;

    function automatic int bit_period(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int half_period(input int bit_per);
        return bit_per / 2;
    endfunction

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        RX_PARITY    = 3'd3,
`endif
        RX_STOP      = 3'd4,
        RX_WAIT_IDLE = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for a single asynchronous bit; RESET_VALUE sets both flops in reset.
module uart_sync2 #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_reg <= RESET_VALUE;
            q_reg    <= RESET_VALUE;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/uart_rx.sv
// 8-bit UART receiver (start, 8 data LSB first, optional even parity, 1 stop) with mid-bit sampling.
// Define UART_RX_PARITY_EN to expect and check an even-parity bit before the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int BIT_PERIOD = bit_period(CLK_FREQ, BAUD_RATE)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_parity_err,
    output logic       rx_busy
);

    localparam logic [BAUD_CNT_W-1:0] BIT_LAST  = BAUD_CNT_W'(BIT_PERIOD - 1);
    localparam logic [BAUD_CNT_W-1:0] HALF_LAST = BAUD_CNT_W'(half_period(BIT_PERIOD) - 1);

    rx_state_t             state_reg, state_next;
    logic [BAUD_CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]            bit_cnt_reg, bit_cnt_next;
    logic [7:0]            shifter_reg, shifter_next;
    logic [7:0]            data_reg, data_next;
    logic                  valid_reg, valid_next;
    logic                  frame_err_reg, frame_err_next;
    logic                  rx_s;
    logic                  rx_s_prev_reg;
    logic                  bit_tick;
`ifdef UART_RX_PARITY_EN
    logic                  parity_bit_reg, parity_bit_next;
    logic                  parity_err_reg, parity_err_next;
`endif

    uart_sync2 #(.RESET_VALUE(1'b1)) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= RX_IDLE;
            baud_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shifter_reg   <= '0;
            data_reg      <= '0;
            valid_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            rx_s_prev_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            baud_cnt_reg  <= baud_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shifter_reg   <= shifter_next;
            data_reg      <= data_next;
            valid_reg     <= valid_next;
            frame_err_reg <= frame_err_next;
            rx_s_prev_reg <= rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_bit_reg <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            parity_bit_reg <= parity_bit_next;
            parity_err_reg <= parity_err_next;
        end
    end
`endif

    always_comb begin
        state_next     = state_reg;
        baud_cnt_next  = baud_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shifter_next   = shifter_reg;
        data_next      = data_reg;
        valid_next     = 1'b0;
        frame_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bit_next = parity_bit_reg;
        parity_err_next = 1'b0;
`endif
        bit_tick = (baud_cnt_reg == BIT_LAST);

        case (state_reg)
            RX_IDLE: begin
                if (rx_s_prev_reg && !rx_s) begin
                    state_next    = RX_START;
                    baud_cnt_next = '0;
                end
            end
            // Re-check the start bit at its middle to reject short glitches.
            RX_START: begin
                if (baud_cnt_reg == HALF_LAST) begin
                    baud_cnt_next = '0;
                    bit_cnt_next  = '0;
                    state_next    = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    baud_cnt_next = baud_cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                baud_cnt_next = bit_tick ? '0 : baud_cnt_reg + 1'b1;
                if (bit_tick) begin
                    shifter_next = {rx_s, shifter_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = RX_PARITY;
`else
                        state_next = RX_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            RX_PARITY: begin
                baud_cnt_next = bit_tick ? '0 : baud_cnt_reg + 1'b1;
                if (bit_tick) begin
                    parity_bit_next = rx_s;
                    state_next      = RX_STOP;
                end
            end
`endif
            // A low stop sample wins over any parity result.
            RX_STOP: begin
                baud_cnt_next = bit_tick ? '0 : baud_cnt_reg + 1'b1;
                if (bit_tick) begin
                    if (rx_s) begin
                        state_next = RX_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{parity_bit_reg, shifter_reg}) begin
                            parity_err_next = 1'b1;
                        end else begin
                            data_next  = shifter_reg;
                            valid_next = 1'b1;
                        end
`else
                        data_next  = shifter_reg;
                        valid_next = 1'b1;
`endif
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_s) begin
                    state_next = RX_IDLE;
                end
            end
            default: begin
                state_next = RX_IDLE;
            end
        endcase
    end

    assign rx_data      = data_reg;
    assign rx_valid     = valid_reg;
    assign rx_frame_err = frame_err_reg;
    assign rx_busy      = (state_reg != RX_IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = parity_err_reg;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule
